// File: rtl/seg7_pkg.sv
// Seven-segment constants shared by the scan decoder and led_driver.
package seg7_pkg;

  localparam int NUM_DIGITS = 4;

  // Segment bit positions inside cathode_n
  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  // Active-low segment patterns (bit0 = a ... bit6 = g) for digits 0..9
  localparam logic [6:0] SEG_CODE_0 = 7'h40;
  localparam logic [6:0] SEG_CODE_1 = 7'h79;
  localparam logic [6:0] SEG_CODE_2 = 7'h24;
  localparam logic [6:0] SEG_CODE_3 = 7'h30;
  localparam logic [6:0] SEG_CODE_4 = 7'h19;
  localparam logic [6:0] SEG_CODE_5 = 7'h12;
  localparam logic [6:0] SEG_CODE_6 = 7'h02;
  localparam logic [6:0] SEG_CODE_7 = 7'h78;
  localparam logic [6:0] SEG_CODE_8 = 7'h00;
  localparam logic [6:0] SEG_CODE_9 = 7'h10;

  // Digit value stored for any unrecognised pattern
  localparam logic [3:0] BCD_INVALID = 4'hF;

  // True when exactly one anode line is driven low
  function automatic logic onehot_low(input logic [3:0] an);
    logic [3:0] act;
    act = ~an;
    return (act != 4'b0) && ((act & (act - 4'd1)) == 4'b0);
  endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational segment-pattern to BCD lookup; dp is not part of the pattern.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] cathode_n,
  output logic [3:0] digit,
  output logic       valid
);

  // Map the ten legal patterns; anything else (including blank) is invalid
  always_comb begin
    digit = BCD_INVALID;
    valid = 1'b1;
    case (cathode_n)
      SEG_CODE_0: digit = 4'd0;
      SEG_CODE_1: digit = 4'd1;
      SEG_CODE_2: digit = 4'd2;
      SEG_CODE_3: digit = 4'd3;
      SEG_CODE_4: digit = 4'd4;
      SEG_CODE_5: digit = 4'd5;
      SEG_CODE_6: digit = 4'd6;
      SEG_CODE_7: digit = 4'd7;
      SEG_CODE_8: digit = 4'd8;
      SEG_CODE_9: digit = 4'd9;
      default:    valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Recovers four BCD digits from a multiplexed active-low 7-seg bus.
// Each digit dwell is captured once after it has been stable for
// SETTLE_CYCLES cycles; a frame is published once all four slots were seen.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  anode_n,
  input  logic [7:0]  cathode_n,
  output logic [15:0] bcd_out,
  output logic        frame_valid,
  output logic        frame_err,
  output logic        bcd_valid,
  output logic        seg_err,
  output logic        anode_err
);

  localparam logic [7:0] SETTLE = 8'(SETTLE_CYCLES);

  logic [3:0]                 anode_q;
  logic [7:0]                 cath_q;
  logic [7:0]                 cnt;
  logic                       captured;
  logic [NUM_DIGITS-1:0]      seen;
  logic                       pend_err;
  logic [NUM_DIGITS-1:0][3:0] shadow;

  logic       change, settled, one_low, multi_low;
  logic       capture, bad_anode, complete;
  logic [3:0] dec_digit;
  logic       dec_valid;
  logic [3:0] cap_mask;
  logic [3:0] seen_base;
  logic       err_base;

  seg7_pattern_decode u_dec (
    .cathode_n (cath_q[6:0]),
    .digit     (dec_digit),
    .valid     (dec_valid)
  );

  // A new pin pair differing from the sampled pair restarts the dwell
  assign change    = (anode_n != anode_q) || (cathode_n != cath_q);
  assign settled   = (cnt == SETTLE) && !captured;
  assign one_low   = onehot_low(anode_q);
  assign multi_low = (anode_q != 4'hF) && !one_low;
  assign capture   = settled && one_low;
  assign bad_anode = settled && multi_low;
  assign complete  = (seen == 4'hF);
  assign cap_mask  = capture ? ~anode_q : 4'b0;
  // A completing frame hands off; a simultaneous capture opens the next one
  assign seen_base = complete ? 4'b0 : seen;
  assign err_base  = complete ? 1'b0 : pend_err;

  // Input sampling plus the per-dwell stability counter and one-shot flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      anode_q  <= 4'hF;
      cath_q   <= 8'hFF;
      cnt      <= 8'd0;
      captured <= 1'b0;
    end else begin
      anode_q <= anode_n;
      cath_q  <= cathode_n;
      if (change) begin
        cnt      <= 8'd0;
        captured <= 1'b0;
      end else begin
        if (cnt != SETTLE) cnt <= cnt + 8'd1;
        if (capture || bad_anode) captured <= 1'b1;
      end
    end
  end

  // Slot capture, frame assembly and the registered status outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seen        <= '0;
      pend_err    <= 1'b0;
      shadow      <= '0;
      bcd_out     <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      bcd_valid   <= 1'b0;
      seg_err     <= 1'b0;
      anode_err   <= 1'b0;
    end else begin
      seen        <= seen_base | cap_mask;
      pend_err    <= err_base | (capture && !dec_valid);
      seg_err     <= capture && !dec_valid;
      anode_err   <= bad_anode;
      frame_valid <= complete;
      for (int i = 0; i < NUM_DIGITS; i++)
        if (cap_mask[i]) shadow[i] <= dec_digit;
      if (complete) begin
        bcd_out   <= shadow;
        frame_err <= pend_err;
        bcd_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Scoreboard bench for seg7_scan_decoder: a reference model predicts each
// completed frame and the seg/anode error pulse counts from the dwells driven.
module tb_seg7_scan_decoder;

  localparam int S = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  anode_n;
  logic [7:0]  cathode_n;
  logic [15:0] bcd_out;
  logic        frame_valid, frame_err, bcd_valid, seg_err, anode_err;

  seg7_scan_decoder #(.SETTLE_CYCLES(S)) dut (
    .clk         (clk),
    .reset       (reset),
    .anode_n     (anode_n),
    .cathode_n   (cathode_n),
    .bcd_out     (bcd_out),
    .frame_valid (frame_valid),
    .frame_err   (frame_err),
    .bcd_valid   (bcd_valid),
    .seg_err     (seg_err),
    .anode_err   (anode_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  logic [6:0] codes [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                             7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  function automatic logic [3:0] ref_dec(input logic [6:0] c);
    for (int i = 0; i < 10; i++)
      if (c == codes[i]) return 4'(i);
    return 4'hF;
  endfunction

  // scoreboard entries: {frame_err, bcd[15:0]}
  logic [16:0] sb [$];

  logic [3:0] m_seen;
  logic [3:0] m_shadow [4];
  logic       m_err;
  logic [3:0] m_prev_an;
  logic [7:0] m_prev_c;
  int         m_len;
  bit         m_fired;
  int exp_seg = 0, exp_an = 0, exp_frames = 0;
  int got_seg = 0, got_an = 0, got_frames = 0;

  task automatic m_reset();
    m_seen    = 4'b0;
    m_err     = 1'b0;
    for (int i = 0; i < 4; i++) m_shadow[i] = 4'h0;
    m_prev_an = 4'hF;
    m_prev_c  = 8'hFF;
    m_len     = 0;
    m_fired   = 1'b0;
  endtask

  // Hold one (anode, cathode) pair for n cycles and advance the model
  task automatic dwell(input logic [3:0] a, input logic [7:0] c, input int n);
    int zeros, idx;
    logic [3:0] d;
    if (a == m_prev_an && c == m_prev_c) m_len += n;
    else begin
      m_len   = n;
      m_fired = 1'b0;
    end
    m_prev_an = a;
    m_prev_c  = c;
    if (!m_fired && m_len >= S + 1) begin
      m_fired = 1'b1;
      zeros = 0;
      idx   = 0;
      for (int i = 0; i < 4; i++)
        if (!a[i]) begin zeros++; idx = i; end
      if (zeros == 1) begin
        d = ref_dec(c[6:0]);
        if (d == 4'hF) begin m_err = 1'b1; exp_seg++; end
        m_shadow[idx] = d;
        m_seen[idx]   = 1'b1;
        if (m_seen == 4'hF) begin
          sb.push_back({m_err, m_shadow[3], m_shadow[2], m_shadow[1], m_shadow[0]});
          exp_frames++;
          m_seen = 4'b0;
          m_err  = 1'b0;
        end
      end else if (zeros > 1) exp_an++;
    end
    anode_n   = a;
    cathode_n = c;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic slot(input int i, input logic [7:0] c);
    logic [3:0] a;
    a = 4'hF;
    a[i] = 1'b0;
    dwell(a, c, 10);
  endtask

  // Pop and compare each published frame; tally error pulses
  always @(negedge clk) begin
    if (!reset) begin
      if (frame_valid) begin
        got_frames++;
        chk("frame_expected", {31'b0, sb.size() != 0}, 32'd1);
        if (sb.size() != 0) begin
          logic [16:0] e;
          e = sb.pop_front();
          chk("bcd_out", {16'b0, bcd_out}, {16'b0, e[15:0]});
          chk("frame_err", {31'b0, frame_err}, {31'b0, e[16]});
        end
      end
      if (seg_err)   got_seg++;
      if (anode_err) got_an++;
    end
  end

  initial begin
    reset     = 1'b1;
    anode_n   = 4'hF;
    cathode_n = 8'hFF;
    m_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {11'b0, bcd_out, frame_valid, frame_err, bcd_valid, seg_err, anode_err}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    // basic frame
    slot(0, 8'h80); slot(1, 8'hB0); slot(2, 8'h92); slot(3, 8'h90);
    dwell(4'hF, 8'hFF, 10);
    chk("basic_frames", got_frames, 1);
    chk("basic_bcd", {16'b0, bcd_out}, 32'h9538);
    chk("basic_bcd_valid", {31'b0, bcd_valid}, 32'd1);

    // glitch: short dwell of digit 1 on slot 0 must not override digit 2
    slot(0, 8'hA4);
    dwell(4'b1110, 8'hF9, 3);
    slot(1, 8'hB0); slot(2, 8'h92); slot(3, 8'h90);
    dwell(4'hF, 8'hFF, 10);
    chk("glitch_bcd", {16'b0, bcd_out}, 32'h9532);

    // invalid code on slot 2, then a clean frame
    slot(0, 8'hC0); slot(1, 8'hF9); slot(2, 8'hFF); slot(3, 8'hA4);
    dwell(4'hF, 8'hFF, 10);
    chk("inv_bcd", {16'b0, bcd_out}, 32'h2F10);
    chk("inv_frame_err", {31'b0, frame_err}, 32'd1);
    chk("inv_seg_pulses", got_seg, 1);
    slot(0, 8'h99); slot(1, 8'h92); slot(2, 8'h82); slot(3, 8'hF8);
    dwell(4'hF, 8'hFF, 10);
    chk("clean_frame_err", {31'b0, frame_err}, 32'd0);

    // illegal anode between partial slots: no capture, seen untouched
    slot(0, 8'hB0); slot(1, 8'h79);
    dwell(4'b1100, 8'hC0, 10);
    chk("anode_pulses", got_an, 1);
    chk("anode_no_frame", got_frames, exp_frames);
    slot(2, 8'h19); slot(3, 8'h02);
    dwell(4'hF, 8'hFF, 10);
    chk("anode_after_bcd", {16'b0, bcd_out}, 32'h6413);

    // reset mid-frame discards the partial frame
    slot(0, 8'h12); slot(1, 8'h24);
    anode_n = 4'hF; cathode_n = 8'hFF;
    reset = 1'b1;
    m_reset();
    #1;
    chk("midreset_bcd_valid", {31'b0, bcd_valid}, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    slot(2, 8'h78); slot(3, 8'h00);
    dwell(4'hF, 8'hFF, 10);
    chk("midreset_no_frame", {31'b0, frame_valid | bcd_valid}, 32'd0);
    slot(0, 8'h12); slot(1, 8'h24);
    dwell(4'hF, 8'hFF, 10);
    chk("midreset_bcd", {16'b0, bcd_out}, 32'h8725);

    // scanner-like traffic: rotating slot order, short blanking gaps
    for (int f = 0; f < 20; f++) begin
      for (int k = 0; k < 4; k++) begin
        int s;
        s = (f + k) % 4;
        slot(s, {1'($urandom_range(0, 1)), codes[$urandom_range(0, 9)]});
        dwell(4'hF, 8'hFF, 2);
      end
    end
    dwell(4'hF, 8'hFF, 20);

    chk("sb_drained", sb.size(), 0);
    chk("frame_count", got_frames, exp_frames);
    chk("seg_err_count", got_seg, exp_seg);
    chk("anode_err_count", got_an, exp_an);
    chk("final_bcd_valid", {31'b0, bcd_valid}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
